// File: rtl/vga_text_console_writer_if.sv
// ---------------------------------------------------------------------------
// vga_text_console_writer_if
//
// Purpose: bundles the character-stream handshake and the Avalon-MM master
// bus of the text console writer into one interface.
//
// Signals:
//   CHAR_VALID       character strobe                (source -> writer)
//   CHAR_READY       writer can accept a character   (writer -> source)
//   CHAR_DATA[7:0]   character code, bit 7 = inverse glyph
//   CHAR_ATTR[7:0]   [7:4] foreground, [3:0] background palette index
//   M_ADDR[11:0]     VRAM word address
//   M_WRITE, M_READ  Avalon write / read requests
//   M_BYTE_EN[3:0]   byte enables
//   M_WRITEDATA[31:0], M_READDATA[31:0]
//   M_READDATAVALID  read data valid
//   M_WAITREQUEST    slave stall
//
// Modports:
//   master - the console writer (Avalon master, character sink)
//   slave  - the surroundings (character source plus VRAM slave)
// ---------------------------------------------------------------------------
interface vga_text_console_writer_if;
  logic        CHAR_VALID;
  logic        CHAR_READY;
  logic [7:0]  CHAR_DATA;
  logic [7:0]  CHAR_ATTR;
  logic [11:0] M_ADDR;
  logic        M_WRITE;
  logic        M_READ;
  logic [3:0]  M_BYTE_EN;
  logic [31:0] M_WRITEDATA;
  logic [31:0] M_READDATA;
  logic        M_READDATAVALID;
  logic        M_WAITREQUEST;

  modport master (
    input  CHAR_VALID, CHAR_DATA, CHAR_ATTR,
    input  M_READDATA, M_READDATAVALID, M_WAITREQUEST,
    output CHAR_READY, M_ADDR, M_WRITE, M_READ, M_BYTE_EN, M_WRITEDATA
  );

  modport slave (
    output CHAR_VALID, CHAR_DATA, CHAR_ATTR,
    output M_READDATA, M_READDATAVALID, M_WAITREQUEST,
    input  CHAR_READY, M_ADDR, M_WRITE, M_READ, M_BYTE_EN, M_WRITEDATA
  );
endinterface

// File: rtl/vga_text_console_writer.sv
// ---------------------------------------------------------------------------
// vga_text_console_writer
//
// Purpose: hardware text console. Takes a stream of characters with a colour
// attribute, keeps a cursor and writes 16-bit cells {char, fg, bg} into an
// 80x30 text VRAM through an Avalon-MM master (two cells per 32-bit word).
// Interprets CR (0x0D), LF (0x0A), BS (0x08) and FF (0x0C, clear screen).
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   bus (master)        character handshake + Avalon-MM master
//   CURSOR_COL[6:0]     current column
//   CURSOR_ROW[4:0]     current row
//   BUSY                high in any state other than IDLE
//
// Build option:
//   SCROLL_EN  defined   : LF / wrap on the last row scrolls the screen up
//                          one row and clears the bottom row.
//              undefined : LF / wrap on the last row homes the cursor to
//                          (0,0); the scroll states are not built.
// ---------------------------------------------------------------------------
module vga_text_console_writer #(
  parameter int COLS      = 80,
  parameter int ROWS      = 30,
  parameter int BASE_ADDR = 0
) (
  input  logic                             CLK,
  input  logic                             RESET,
  vga_text_console_writer_if.master        bus,
  output logic [6:0]                       CURSOR_COL,
  output logic [4:0]                       CURSOR_ROW,
  output logic                             BUSY
);

  localparam logic [11:0] BASE_W   = 12'(BASE_ADDR);
  localparam logic [10:0] CLR_LAST = 11'(ROWS * COLS / 2 - 1);
  localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
`ifdef SCROLL_EN
  localparam logic [10:0] SCR_LAST  = 11'((ROWS - 1) * COLS / 2 - 1);
  localparam logic [10:0] ROW_WORDS = 11'(COLS / 2);
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUT      = 3'd1,
    S_ADV      = 3'd2,
`ifdef SCROLL_EN
    S_SCR_RD   = 3'd3,
    S_SCR_WAIT = 3'd4,
    S_SCR_WR   = 3'd5,
`endif
    S_CLR_WR   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        pending_q, pending_d;   // character latched, not yet decoded
  logic [7:0]  char_q, char_d;
  logic [7:0]  attr_q, attr_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [10:0] waddr_q, waddr_d;       // word counter for clear / scroll
`ifdef SCROLL_EN
  logic [31:0] rdata_q, rdata_d;
  logic        scroll_q, scroll_d;     // current CLR_WR finishes a scroll
`else
  logic        unused_rd;
  assign unused_rd = ^{bus.M_READDATA, bus.M_READDATAVALID};
`endif

  logic        newline;
  logic [11:0] cell_idx;
  logic [31:0] put_data;
  logic [31:0] clr_data;

  assign cell_idx = 12'(row_q) * 12'(COLS) + 12'(col_q);
  // Cell is replicated into both halves; byte enables select the live one.
  assign put_data = {char_q, attr_q, char_q, attr_q};
  assign clr_data = {8'h00, attr_q, 8'h00, attr_q};

  assign CURSOR_COL = col_q;
  assign CURSOR_ROW = row_q;
  assign BUSY       = (state_q != S_IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      char_q    <= '0;
      attr_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      waddr_q   <= '0;
`ifdef SCROLL_EN
      rdata_q   <= '0;
      scroll_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      char_q    <= char_d;
      attr_q    <= attr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      waddr_q   <= waddr_d;
`ifdef SCROLL_EN
      rdata_q   <= rdata_d;
      scroll_q  <= scroll_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    char_d    = char_q;
    attr_d    = attr_q;
    col_d     = col_q;
    row_d     = row_q;
    waddr_d   = waddr_q;
`ifdef SCROLL_EN
    rdata_d   = rdata_q;
    scroll_d  = scroll_q;
`endif
    newline         = 1'b0;
    bus.CHAR_READY  = 1'b0;
    bus.M_ADDR      = '0;
    bus.M_WRITE     = 1'b0;
    bus.M_READ      = 1'b0;
    bus.M_BYTE_EN   = '0;
    bus.M_WRITEDATA = '0;

    case (state_q)
      S_IDLE: begin
        // Acceptance and decode take separate cycles, so READY is low for
        // the cycle in which the latched character is decoded.
        bus.CHAR_READY = ~pending_q;
        if (pending_q) begin
          pending_d = 1'b0;
          case (char_q)
            8'h0D: col_d = '0;
            8'h0A: newline = 1'b1;
            8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
            8'h0C: begin
              waddr_d = '0;
`ifdef SCROLL_EN
              scroll_d = 1'b0;
`endif
              state_d = S_CLR_WR;
            end
            default: state_d = S_PUT;
          endcase
        end else if (bus.CHAR_VALID) begin
          char_d    = bus.CHAR_DATA;
          attr_d    = bus.CHAR_ATTR;
          pending_d = 1'b1;
        end
      end

      S_PUT: begin
        bus.M_WRITE     = 1'b1;
        bus.M_ADDR      = BASE_W + {1'b0, cell_idx[11:1]};
        bus.M_BYTE_EN   = cell_idx[0] ? 4'b1100 : 4'b0011;
        bus.M_WRITEDATA = put_data;
        if (!bus.M_WAITREQUEST) state_d = S_ADV;
      end

      S_ADV: begin
        if (col_q == COL_LAST) begin
          newline = 1'b1;
        end else begin
          col_d   = col_q + 7'd1;
          state_d = S_IDLE;
        end
      end

`ifdef SCROLL_EN
      S_SCR_RD: begin
        bus.M_READ = 1'b1;
        bus.M_ADDR = BASE_W + {1'b0, waddr_q + ROW_WORDS};
        if (!bus.M_WAITREQUEST) state_d = S_SCR_WAIT;
      end

      S_SCR_WAIT: begin
        if (bus.M_READDATAVALID) begin
          rdata_d = bus.M_READDATA;
          state_d = S_SCR_WR;
        end
      end

      S_SCR_WR: begin
        bus.M_WRITE     = 1'b1;
        bus.M_ADDR      = BASE_W + {1'b0, waddr_q};
        bus.M_BYTE_EN   = 4'b1111;
        bus.M_WRITEDATA = rdata_q;
        if (!bus.M_WAITREQUEST) begin
          // Counter runs straight on into the bottom-row clear.
          waddr_d = waddr_q + 11'd1;
          state_d = (waddr_q == SCR_LAST) ? S_CLR_WR : S_SCR_RD;
        end
      end
`endif

      S_CLR_WR: begin
        bus.M_WRITE     = 1'b1;
        bus.M_ADDR      = BASE_W + {1'b0, waddr_q};
        bus.M_BYTE_EN   = 4'b1111;
        bus.M_WRITEDATA = clr_data;
        if (!bus.M_WAITREQUEST) begin
          if (waddr_q == CLR_LAST) begin
            col_d   = '0;
`ifdef SCROLL_EN
            row_d   = scroll_q ? row_q : 5'd0;
`else
            row_d   = '0;
`endif
            state_d = S_IDLE;
          end else begin
            waddr_d = waddr_q + 11'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Shared newline handling for LF and for wrapping past the last column.
    if (newline) begin
      if (row_q != ROW_LAST) begin
        row_d   = row_q + 5'd1;
        col_d   = '0;
        state_d = S_IDLE;
      end else begin
`ifdef SCROLL_EN
        // Cursor is left alone until the scroll completes.
        waddr_d  = '0;
        scroll_d = 1'b1;
        state_d  = S_SCR_RD;
`else
        row_d   = '0;
        col_d   = '0;
        state_d = S_IDLE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vga_text_console_writer.sv
`timescale 1ns/1ps
module tb_vga_text_console_writer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [6:0] CURSOR_COL;
  logic [4:0] CURSOR_ROW;
  logic       BUSY;

  vga_text_console_writer_if bus();

  vga_text_console_writer #(.COLS(80), .ROWS(30), .BASE_ADDR(0)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .bus        (bus),
    .CURSOR_COL (CURSOR_COL),
    .CURSOR_ROW (CURSOR_ROW),
    .BUSY       (BUSY)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mem [0:4095];
  int          stall_n = 0;
  int          n_wr = 0;
  int          n_rd = 0;
  int          last_wr_cycles = 0;
  int          busy_low_wr = 0;
  logic        ready_after = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.be = be; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_cell(input int col, input int row, input logic [7:0] ch, input logic [7:0] at);
    int idx;
    idx = row * 80 + col;
    push_exp(12'(idx / 2), (idx % 2 == 1) ? 4'b1100 : 4'b0011, {ch, at, ch, at});
  endtask

  // Handshake only; returns at the negedge after the transfer.
  task automatic offer(input logic [7:0] c, input logic [7:0] a);
    int n;
    n = 0;
    while (bus.CHAR_READY !== 1'b1 && n < 20000) begin @(negedge CLK); n++; end
    if (n >= 20000) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got CHAR_READY=%b expected 1", bus.CHAR_READY);
    end
    bus.CHAR_VALID = 1'b1;
    bus.CHAR_DATA  = c;
    bus.CHAR_ATTR  = a;
    @(negedge CLK);
    bus.CHAR_VALID = 1'b0;
    ready_after = bus.CHAR_READY;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int n;
    offer(c, a);
    n = 0;
    while (bus.CHAR_READY !== 1'b1 && n < 20000) begin @(negedge CLK); n++; end
    if (n >= 20000) begin
      tests++; fails++;
      $display("FAIL idle_timeout: char %h got CHAR_READY=%b expected 1", c, bus.CHAR_READY);
    end
    $display("[TB] char %h attr %h -> cursor (%0d,%0d) writes %0d reads %0d",
             c, a, CURSOR_COL, CURSOR_ROW, n_wr, n_rd);
  endtask

  // VRAM slave model and scoreboard monitor, evaluated away from the active edge.
  initial begin
    int          stall_cnt;
    int          rd_cnt;
    int          wr_cycles;
    logic [11:0] rd_addr;
    logic        prev_stall;
    logic [11:0] p_addr;
    logic [3:0]  p_be;
    logic [31:0] p_data;
    logic        p_wr;
    logic [31:0] mask;
    wr_t         e;
    stall_cnt = 0; rd_cnt = 0; wr_cycles = 0; rd_addr = '0; prev_stall = 1'b0;
    p_addr = '0; p_be = '0; p_data = '0; p_wr = 1'b0;
    bus.M_WAITREQUEST   = 1'b0;
    bus.M_READDATAVALID = 1'b0;
    bus.M_READDATA      = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        bus.M_WAITREQUEST   = 1'b0;
        bus.M_READDATAVALID = 1'b0;
        stall_cnt = 0; rd_cnt = 0; wr_cycles = 0; prev_stall = 1'b0;
      end else begin
        bus.M_READDATAVALID = 1'b0;
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            bus.M_READDATAVALID = 1'b1;
            bus.M_READDATA      = mem[rd_addr];
          end
        end
        if (prev_stall) begin
          tests++;
          if (bus.M_WRITE !== p_wr || bus.M_ADDR !== p_addr || bus.M_BYTE_EN !== p_be ||
              bus.M_WRITEDATA !== p_data) begin
            fails++;
            $display("FAIL stall_stable: got wr=%b addr=%h be=%b data=%h expected wr=%b addr=%h be=%b data=%h",
                     bus.M_WRITE, bus.M_ADDR, bus.M_BYTE_EN, bus.M_WRITEDATA, p_wr, p_addr, p_be, p_data);
          end
        end
        if (bus.M_WRITE || bus.M_READ) begin
          if (stall_cnt < stall_n) begin
            bus.M_WAITREQUEST = 1'b1;
            stall_cnt++;
          end else begin
            bus.M_WAITREQUEST = 1'b0;
            stall_cnt = 0;
          end
          if (bus.M_WRITE) wr_cycles++;
          prev_stall = bus.M_WAITREQUEST;
          p_wr = bus.M_WRITE; p_addr = bus.M_ADDR; p_be = bus.M_BYTE_EN; p_data = bus.M_WRITEDATA;
          if (!bus.M_WAITREQUEST && bus.M_WRITE) begin
            n_wr++;
            last_wr_cycles = wr_cycles;
            wr_cycles = 0;
            if (!BUSY) busy_low_wr++;
            for (int b = 0; b < 4; b++)
              if (bus.M_BYTE_EN[b]) mem[bus.M_ADDR][b*8 +: 8] = bus.M_WRITEDATA[b*8 +: 8];
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL unexpected_write: got addr=%h be=%b data=%h expected no write",
                       bus.M_ADDR, bus.M_BYTE_EN, bus.M_WRITEDATA);
            end else begin
              e = exp_q.pop_front();
              mask = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
              if (bus.M_ADDR !== e.addr || bus.M_BYTE_EN !== e.be ||
                  (bus.M_WRITEDATA & mask) !== (e.data & mask)) begin
                fails++;
                $display("FAIL write: got addr=%h be=%b data=%h expected addr=%h be=%b data=%h",
                         bus.M_ADDR, bus.M_BYTE_EN, bus.M_WRITEDATA, e.addr, e.be, e.data);
              end
            end
          end else if (!bus.M_WAITREQUEST && bus.M_READ) begin
            n_rd++;
            rd_addr = bus.M_ADDR;
            rd_cnt  = 2;
          end
        end else begin
          bus.M_WAITREQUEST = 1'b0;
          prev_stall = 1'b0;
        end
      end
    end
  end

  initial begin
    int base_wr;
    int base_rd;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    bus.CHAR_VALID = 1'b0;
    bus.CHAR_DATA  = '0;
    bus.CHAR_ATTR  = '0;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);

    // Reset state.
    check("rst_ready", 32'(bus.CHAR_READY), 32'd1);
    check("rst_write", 32'(bus.M_WRITE), 32'd0);
    check("rst_read", 32'(bus.M_READ), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_addr", 32'(bus.M_ADDR), 32'd0);
    check("rst_be", 32'(bus.M_BYTE_EN), 32'd0);
    check("rst_wdata", bus.M_WRITEDATA, 32'd0);
    check("rst_cursor", {20'd0, CURSOR_ROW, CURSOR_COL}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // 'A' at (0,0).
    push_exp(12'h000, 4'b0011, 32'h411F_411F);
    send(8'h41, 8'h1F);
    check("A_ready_drop", 32'(ready_after), 32'd0);
    check("A_nwr", n_wr, 1);
    check("A_cursor", {20'd0, CURSOR_ROW, CURSOR_COL}, {20'd0, 5'd0, 7'd1});
    check("A_ready_back", 32'(bus.CHAR_READY), 32'd1);

    // 'B' at (1,0) with three wait states.
    stall_n = 3;
    push_exp(12'h000, 4'b1100, 32'h422E_422E);
    send(8'h42, 8'h2E);
    stall_n = 0;
    check("B_hold_cycles", last_wr_cycles, 4);
    check("B_nwr", n_wr, 2);

    // Full row of printables from (0,0), then BS x3 and CR.
    RESET = 1'b1; @(negedge CLK); RESET = 1'b0; @(negedge CLK);
    base_wr = n_wr;
    for (int i = 0; i < 80; i++) begin
      push_cell(i, 0, 8'(8'h20 + i), 8'h5A);
      send(8'(8'h20 + i), 8'h5A);
    end
    check("row_nwr", n_wr - base_wr, 80);
    check("row_cursor", {20'd0, CURSOR_ROW, CURSOR_COL}, {20'd0, 5'd1, 7'd0});
    base_wr = n_wr;
    for (int i = 0; i < 3; i++) send(8'h08, 8'h00);
    check("bs_cursor", {20'd0, CURSOR_ROW, CURSOR_COL}, {20'd0, 5'd1, 7'd0});
    send(8'h0D, 8'h00);
    check("bs_cr_nobus", n_wr - base_wr, 0);
    check("bs_cr_noread", n_rd, 0);

    // Form feed clears the whole screen.
    base_wr = n_wr;
    busy_low_wr = 0;
    for (int w = 0; w < 1200; w++) push_exp(12'(w), 4'b1111, 32'h0007_0007);
    send(8'h0C, 8'h07);
    check("ff_nwr", n_wr - base_wr, 1200);
    check("ff_cursor", {20'd0, CURSOR_ROW, CURSOR_COL}, 32'd0);
    check("ff_busy", busy_low_wr, 0);

`ifdef SCROLL_EN
    // Scroll from (5,29).
    for (int r = 0; r < 29; r++) send(8'h0A, 8'h07);
    for (int c = 0; c < 5; c++) begin
      push_cell(c, 29, 8'h61, 8'h1F);
      send(8'h61, 8'h1F);
    end
    check("pre_scroll_cursor", {20'd0, CURSOR_ROW, CURSOR_COL}, {20'd0, 5'd29, 7'd5});
    mem[12'h028] = 32'hDEAD_BEEF;
    for (int w = 0; w < 1160; w++) push_exp(12'(w), 4'b1111, mem[w + 40]);
    for (int w = 1160; w < 1200; w++) push_exp(12'(w), 4'b1111, 32'h0007_0007);
    base_rd = n_rd;
    send(8'h0A, 8'h07);
    check("scroll_word0", mem[0], 32'hDEAD_BEEF);
    check("scroll_lastrow", mem[12'h4AF], 32'h0007_0007);
    check("scroll_nrd", n_rd - base_rd, 1160);
    check("scroll_cursor", {20'd0, CURSOR_ROW, CURSOR_COL}, {20'd0, 5'd29, 7'd0});
`else
    // Wrap at (79,29) homes the cursor.
    base_rd = n_rd;
    for (int r = 0; r < 29; r++) send(8'h0A, 8'h07);
    check("lf_cursor", {20'd0, CURSOR_ROW, CURSOR_COL}, {20'd0, 5'd29, 7'd0});
    for (int c = 0; c < 79; c++) begin
      push_cell(c, 29, 8'h2E, 8'h34);
      send(8'h2E, 8'h34);
    end
    check("wrap_pre_cursor", {20'd0, CURSOR_ROW, CURSOR_COL}, {20'd0, 5'd29, 7'd79});
    push_exp(12'h4AF, 4'b1100, 32'h5A4E_5A4E);
    send(8'h5A, 8'h4E);
    check("wrap_cursor", {20'd0, CURSOR_ROW, CURSOR_COL}, 32'd0);
    check("wrap_noread", n_rd - base_rd, 0);
`endif

    // Reset in the middle of a clear.
    RESET = 1'b1; @(negedge CLK); RESET = 1'b0; @(negedge CLK);
    push_cell(0, 0, 8'h51, 8'h12);
    send(8'h51, 8'h12);
    for (int w = 0; w < 1200; w++) push_exp(12'(w), 4'b1111, 32'h0003_0003);
    offer(8'h0C, 8'h03);
    repeat (20) @(negedge CLK);
    check("midclr_busy", 32'(BUSY), 32'd1);
    RESET = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    check("midrst_write", 32'(bus.M_WRITE), 32'd0);
    check("midrst_busy", 32'(BUSY), 32'd0);
    check("midrst_outs", {bus.M_ADDR, bus.M_BYTE_EN, 3'd0, bus.M_READ, 12'd0}, 32'd0);
    check("midrst_wdata", bus.M_WRITEDATA, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    check("midrst_ready", 32'(bus.CHAR_READY), 32'd1);
    check("midrst_cursor", {20'd0, CURSOR_ROW, CURSOR_COL}, 32'd0);
    push_cell(0, 0, 8'h43, 8'h21);
    send(8'h43, 8'h21);
    check("post_rst_cursor", {20'd0, CURSOR_ROW, CURSOR_COL}, {20'd0, 5'd0, 7'd1});

    repeat (4) @(negedge CLK);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_text_console_writer.md
Name: vga_text_console_writer

Overview:
- Hardware text console feeding the VGA text-mode VRAM through its Avalon-MM slave port. Accepts a stream of byte characters plus a colour attribute, keeps a cursor, and writes 16-bit cells into the 80x30 VRAM.
- Interprets CR, LF, BS and FF. Clears the screen on FF and scrolls the screen up one row on overflow.
- Sits directly upstream of the VGA text controller and shares its VRAM port with the CPU through the Platform Designer interconnect.

Parameters:
- COLS, 80, characters per row; must be even (2 cells per 32-bit word).
- ROWS, 30, number of rows.
- BASE_ADDR, 0, word address of cell (0,0) in the slave's address space.

Ports:
- CLK  in  1  system clock, 50 MHz
- RESET  in  1  asynchronous, active-high reset
- CHAR_VALID  in  1  character strobe
- CHAR_READY  out  1  block can accept a character
- CHAR_DATA  in  8  character code; bit 7 = inverse-glyph flag
- CHAR_ATTR  in  8  [7:4] foreground palette index, [3:0] background palette index
- M_ADDR  out  12  word address to the VRAM slave
- M_WRITE  out  1  Avalon write
- M_READ  out  1  Avalon read
- M_BYTE_EN  out  4  byte enables
- M_WRITEDATA  out  32  write data
- M_READDATA  in  32  read data
- M_READDATAVALID  in  1  read data valid
- M_WAITREQUEST  in  1  slave stall
- CURSOR_COL  out  7  current column
- CURSOR_ROW  out  5  current row
- BUSY  out  1  high in any state other than IDLE

Behaviour:
- Cell format (16 bits): {char[7:0], fg[3:0], bg[3:0]}.
- Cell mapping:
  - Cell index = row*COLS + col.
  - Word = BASE_ADDR + index>>1.
  - Even index uses bits [15:0] with BE 0011; odd index uses bits [31:16] with BE 1100.
- Reset: all outputs 0 except CHAR_READY. Cursor = (0,0). State = IDLE. No VRAM clear on reset.
- Handshake:
  - CHAR_READY = 1 only in IDLE.
  - A transfer occurs on a cycle with CHAR_VALID & CHAR_READY; CHAR_DATA and CHAR_ATTR are latched.
  - Next state is decided in the following cycle; CHAR_READY drops the cycle after acceptance.
- Avalon master:
  - M_WRITE and M_READ are held with stable address, data and byte enables until a cycle with M_WAITREQUEST = 0.
  - At most one read outstanding; the block waits for M_READDATAVALID before issuing the next access.
- States: IDLE, PUT, ADV, SCR_RD, SCR_WAIT, SCR_WR, CLR_WR.
- Character handling:
  - Printable (anything except 0x08, 0x0A, 0x0C, 0x0D): PUT writes the cell, then ADV.
  - ADV: col+1; if col was COLS-1, col = 0 and a newline is performed.
  - 0x0D: col = 0, back to IDLE. No bus access, 1 cycle.
  - 0x0A: col = 0, newline.
  - 0x08: col-1 if col > 0, else no change. No erase.
  - 0x0C: CLR_WR writes ROWS*COLS/2 words with BE 1111 and data {8'h00, attr, 8'h00, attr}; then cursor = (0,0).
- Newline: if row < ROWS-1, row+1 and go to IDLE. Otherwise behaviour depends on SCROLL_EN (see Optional Feature).
- Scroll:
  - For w = 0 .. (ROWS-1)*COLS/2-1: SCR_RD reads word w+COLS/2, SCR_WAIT waits for valid, SCR_WR writes that data to word w with BE 1111.
  - Then CLR_WR clears the last row's COLS/2 words with the latched attr.
  - Row stays ROWS-1.
- Address counter: 11 bits, compared against (ROWS-1)*COLS/2-1 and ROWS*COLS/2-1. No wrap.
- Reset mid-operation aborts immediately, leaving VRAM partially updated. M_READDATAVALID arriving after reset is ignored.
- CURSOR_COL and CURSOR_ROW update in the same cycle the state machine returns to IDLE.

Optional Feature:
- Macro: SCROLL_EN.
- Defined: newline on the last row performs the scroll sequence above.
- Undefined: newline on the last row sets row = 0 and col = 0, and the scroll states are not synthesised. FF clear is still present.

Test Plan:
- Reset, then send 'A' (0x41), attr 0x1F → one write to addr 0x000 with BE 0011, data[15:0] = 0x411F; cursor = (1,0); CHAR_READY returns high.
- Cursor at (1,0), send 'B' attr 0x2E with M_WAITREQUEST held for 3 cycles → write held stable for 4 cycles to addr 0x000 with BE 1100, data[31:16] = 0x422E; exactly one write completes.
- Send 80 printable characters from (0,0) → 80 writes covering addr 0x000–0x027; cursor = (0,1). Then send 0x08 three times → cursor = (0,1) with no bus activity. Then 0x0D → no bus activity.
- Send 0x0C attr 0x07 → 1200 writes covering addr 0x000–0x4AF, all with data 0x00070007; cursor = (0,0); BUSY high throughout.
- SCROLL_EN defined: pre-load word 0x028 = 0xDEADBEEF, cursor at (5,29), send 0x0A with the slave returning data 2 cycles after each read → word 0x000 = 0xDEADBEEF; words 0x488–0x4AF cleared; cursor = (0,29).
- SCROLL_EN undefined: cursor at (79,29), send 'Z' → write to 0x4AF with BE 1100; cursor = (0,0); no reads issued. Separately, assert RESET during a clear → all outputs 0, cursor (0,0), CHAR_READY = 1 after release.
